// File: rtl/fb_pkg.sv
// Shared framebuffer constants, the scheduler state encoding and colour constants
// for the framebuffer write path.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 24;

  localparam logic [FB_DATA_W-1:0] CLR_BLACK = 24'h000000;
  localparam logic [FB_DATA_W-1:0] CLR_WHITE = 24'hffffff;
  localparam logic [FB_DATA_W-1:0] CLR_RED   = 24'hff0000;
  localparam logic [FB_DATA_W-1:0] CLR_GREEN = 24'h00ff00;
  localparam logic [FB_DATA_W-1:0] CLR_BLUE  = 24'h0000ff;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } sched_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr
// (wrapping) wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = fb_pkg::idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int j;

  // NOTE: every output gets a default before the search so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Shares the single framebuffer write port between pixel-write requesters and a
// built-in full-frame clear sequencer; one registered write per cycle.
module fb_write_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = fb_pkg::FB_ADDR_W,
  parameter int DATA_W   = fb_pkg::FB_DATA_W,
  parameter int FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]            req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]            req_data,
  input  logic                                 clear_start,
  input  logic [DATA_W-1:0]                    clear_color,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  output logic                                 fb_writing,
  output logic [ADDR_W-1:0]                    fb_waddr,
  output logic [DATA_W-1:0]                    fb_wdata,
  output logic [fb_pkg::idx_w(NUM_REQ)-1:0]    grant_id
);

  import fb_pkg::*;

  localparam int                IDX_W     = idx_w(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  gid_q, gid_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    gid_d     = gid_q;
    busy_d    = 1'b0;
    last_d    = 1'b0;
    done_d    = last_q;
    req_ready = '0;

    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          // Address 0 is written on the accepting edge so the sweep has no gap.
          color_d = clear_color;
          wr_d    = 1'b1;
          waddr_d = '0;
          wdata_d = clear_color;
          gid_d   = '0;
          busy_d  = 1'b1;
          if (FB_WORDS == 1) begin
            last_d = 1'b1;
          end else begin
            state_d = CLEAR;
            cnt_d   = ADDR_W'(1);
          end
        end else if (arb_any) begin
          // Reset gates ready so no requester sees an accept while held in reset.
          req_ready = rst_n ? arb_gnt : '0;
          wr_d      = 1'b1;
          waddr_d   = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d   = req_data[int'(arb_idx)*DATA_W +: DATA_W];
          gid_d     = arb_idx;
          rr_ptr_d  = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
        end
      end
      CLEAR: begin
        wr_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = color_q;
        gid_d   = '0;
        busy_d  = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          last_d  = 1'b1;
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      color_q  <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign fb_writing = wr_q;
  assign fb_waddr   = waddr_q;
  assign fb_wdata   = wdata_q;
  assign grant_id   = gid_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule
